// File: rtl/regfile_sb.sv
// Scoreboarded register file: NRD combinational read ports, one byte-strobed write port,
// busy bits for pending writebacks, same-cycle bypass and a non-forwarding debug read port.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NRD*ADDR_W-1:0]  i_raddr,
    output logic [NRD*DATA_W-1:0]  o_rdata,
    output logic [NRD-1:0]         o_rbusy,
    input  logic                   i_wen,
    input  logic [ADDR_W-1:0]      i_waddr,
    input  logic [DATA_W-1:0]      i_wdata,
    input  logic [DATA_W/8-1:0]    i_wstrb,
    input  logic                   i_mark_en,
    input  logic [ADDR_W-1:0]      i_mark_addr,
    output logic                   o_mark_err,
    output logic [ADDR_W:0]        o_busy_cnt,
    input  logic [ADDR_W-1:0]      i_dbg_addr,
    output logic [DATA_W-1:0]      o_dbg_data
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int NB    = DATA_W/8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic              r_mark_err;
    logic [ADDR_W:0]   r_busy_cnt;

    logic              w_wr_ok;
    logic              w_mk_ok;
    logic              w_mark_err_nxt;
    logic [DATA_W-1:0] w_wmerge;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic [ADDR_W:0]   w_cnt_nxt;

    assign w_wr_ok = i_wen     && !(ZERO_REG != 0 && i_waddr == '0);
    assign w_mk_ok = i_mark_en && !(ZERO_REG != 0 && i_mark_addr == '0);

    // Stored word with the strobed write bytes merged in; used for both the update and the bypass.
    always_comb begin
        w_wmerge = r_mem[i_waddr];
        for (int k = 0; k < NB; k++) begin
            if (i_wstrb[k]) w_wmerge[k*8 +: 8] = i_wdata[k*8 +: 8];
        end
    end

    // Mark is applied after the write clear so a same-cycle mark wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_ok) w_busy_nxt[i_waddr] = 1'b0;
        if (w_mk_ok) w_busy_nxt[i_mark_addr] = 1'b1;
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int j = 0; j < DEPTH; j++) begin
            w_cnt_nxt = w_cnt_nxt + (ADDR_W+1)'(w_busy_nxt[j]);
        end
    end

    assign w_mark_err_nxt = w_mk_ok && r_busy[i_mark_addr]
                            && !(w_wr_ok && i_waddr == i_mark_addr);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int j = 0; j < DEPTH; j++) r_mem[j] <= '0;
            r_busy     <= '0;
            r_mark_err <= 1'b0;
            r_busy_cnt <= '0;
        end else begin
            if (w_wr_ok) r_mem[i_waddr] <= w_wmerge;
            r_busy     <= w_busy_nxt;
            r_mark_err <= w_mark_err_nxt;
            r_busy_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        o_rdata = '0;
        o_rbusy = '0;
        for (int p = 0; p < NRD; p++) begin
            if (ZERO_REG != 0 && i_raddr[p*ADDR_W +: ADDR_W] == '0) begin
                o_rdata[p*DATA_W +: DATA_W] = '0;
                o_rbusy[p]                  = 1'b0;
            end else if (BYPASS != 0 && w_wr_ok && i_waddr == i_raddr[p*ADDR_W +: ADDR_W]) begin
                o_rdata[p*DATA_W +: DATA_W] = w_wmerge;
                o_rbusy[p]                  = 1'b0;
            end else begin
                o_rdata[p*DATA_W +: DATA_W] = r_mem[i_raddr[p*ADDR_W +: ADDR_W]];
                o_rbusy[p]                  = r_busy[i_raddr[p*ADDR_W +: ADDR_W]];
            end
        end
    end

    assign o_dbg_data = (ZERO_REG != 0 && i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];
    assign o_mark_err = r_mark_err;
    assign o_busy_cnt = r_busy_cnt;

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised, scoreboarded general-purpose register file for the next CPU core generation. It adds the following to a plain 2R1W file:
- configurable width, depth and read-port count;
- byte-strobed writes;
- same-cycle write-to-read bypass;
- per-register busy bits that track outstanding long-latency writebacks (loads, multiply).

Sits between decode (reads, busy marking) and writeback (writes). The debug port replaces per-register output buses.

Parameters:
DATA_W, 32, register width in bits; must be a multiple of 8.
ADDR_W, 5, address width; depth = 2**ADDR_W.
NRD, 2, number of read ports.
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and marks.
BYPASS, 1, 1 = same-cycle write forwarded to read ports.

Ports:
clk  in  1  clock; all state updates on its rising edge.
rst  in  1  synchronous, active-high reset.
raddr  in  NRD*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W].
rdata  out  NRD*DATA_W  read data, combinational.
rbusy  out  NRD  busy flag of each read address, combinational.
wen  in  1  write enable.
waddr  in  ADDR_W  write address.
wdata  in  DATA_W  write data.
wstrb  in  DATA_W/8  byte enables for the write.
mark_en  in  1  set busy bit of mark_addr (issue of a pending writeback).
mark_addr  in  ADDR_W  register to mark.
mark_err  out  1  registered; marking an already-busy register was attempted.
busy_cnt  out  ADDR_W+1  registered count of currently busy registers.
dbg_addr  in  ADDR_W  debug read address.
dbg_data  out  DATA_W  stored value at dbg_addr; combinational, no bypass.

Behaviour:
- Reset (rst=1 at a clk edge):
  - all registers and busy bits become 0; busy_cnt=0, mark_err=0;
  - wen and mark_en are ignored that cycle;
  - rst has priority over everything, including mid-sequence writes/marks.
- Write: at the edge, if wen and not (ZERO_REG and waddr==0):
  - byte k of reg[waddr] takes wdata byte k where wstrb[k]=1; other bytes are held;
  - busy[waddr] is cleared.
  - wstrb=0 with wen=1 still clears busy, data unchanged.
- Mark: at the edge, if mark_en and not (ZERO_REG and mark_addr==0), busy[mark_addr] is set.
- Mark and write to the same address in one cycle: busy ends set (mark wins); data is written.
- Read port i, combinational, with a = raddr_i:
  - ZERO_REG and a==0: rdata_i=0, rbusy_i=0.
  - BYPASS=1 and wen and waddr==a (not the zero register):
    - rdata_i = stored value with strobed wdata bytes merged;
    - rbusy_i = 0.
  - Otherwise: rdata_i = reg[a], rbusy_i = busy[a].
  - A same-cycle mark never affects rbusy in that cycle; it is visible from the next cycle.
- BYPASS=0: a write is visible on reads from the cycle after the edge.
- Read ports are independent; any ports may share an address.
- mark_err is asserted for exactly the cycle after an edge where all of these held:
  - mark_en=1;
  - busy[mark_addr] was 1;
  - that register was not cleared by a write at that same edge.
  - mark_addr is not the zero register when ZERO_REG=1.
  - Otherwise mark_err is 0. The state update still occurs (bit stays set).
- busy_cnt equals the population of the busy bits after each edge. It is updated every cycle, never wraps, and max = 2**ADDR_W (ZERO_REG=1: 2**ADDR_W - 1).
- dbg_data: reg[dbg_addr]; 0 for address 0 when ZERO_REG=1.

Test Plan:
- Reset, then read every address on all ports -> rdata=0, rbusy=0, busy_cnt=0. Write 0xDEADBEEF to r0 -> r0 still reads 0.
- wen=1, waddr=5, wdata=0x11223344, wstrb=4'b0101 over stored 0xAABBCCDD -> same cycle rdata (raddr=5, BYPASS=1) = 0xAA22CC44. Next cycle dbg_data=0xAA22CC44. With BYPASS=0, same-cycle rdata=0xAABBCCDD.
- mark r7 -> next cycle rbusy=1, busy_cnt=1. Write r7 -> same cycle rbusy=0 (BYPASS=1); after edge busy_cnt=0.
- mark r9 and write r9 in one cycle -> busy[9]=1, data updated, busy_cnt=1, mark_err=0.
- mark r3 twice on consecutive cycles -> mark_err=1 for one cycle after the second edge. Write+mark r3 in one cycle -> mark_err=0.
- Mark r1..r31 then assert rst mid-sequence -> next cycle all rbusy=0, busy_cnt=0, registers 0. Check the busy_cnt=31 peak before reset.
